// File: rtl/operand_collector.sv
// Operand collector: pairs operand A and B streams for one functional unit.
// Optional divide-by-zero guard enabled by defining OPCOL_DIV_ZERO_GUARD_EN.
module operand_collector #(
   parameter int size = 32
) (
   input  logic            CGRA_Clock,
   input  logic            CGRA_Reset,
   input  logic            cfg_load,
   input  logic [3:0]      cfg_select,
   input  logic            a_valid,
   input  logic [size-1:0] a_data,
   output logic            a_ready,
   input  logic            b_valid,
   input  logic [size-1:0] b_data,
   output logic            b_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [size-1:0] out_a,
   output logic [size-1:0] out_b,
   output logic [3:0]      out_select,
   output logic            div_zero
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HAVE_A = 2'd1,
      HAVE_B = 2'd2,
      FULL   = 2'd3
   } state_t;

   localparam logic [3:0] SEL_DIV = 4'd3;
   localparam logic [size-1:0] ONE = {{(size-1){1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [size-1:0] a_q, a_d;
   logic [size-1:0] b_q, b_d;
   logic [3:0]      op_q, op_d;
   logic [3:0]      sel_q, sel_d;
   logic            dz_q, dz_d;

   logic            hs_a, hs_b, retire, complete, guard;
   logic [size-1:0] b_fin;
   logic [3:0]      sel_snap;

   // Readys depend only on state, out_ready and reset, never on valids.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (!CGRA_Reset) begin
         unique case (state_q)
            EMPTY: begin
               a_ready = 1'b1;
               b_ready = 1'b1;
            end
            HAVE_A: b_ready = 1'b1;
            HAVE_B: a_ready = 1'b1;
            FULL: begin
               a_ready = out_ready;
               b_ready = out_ready;
            end
            default: ;
         endcase
      end
   end

   assign hs_a   = a_valid & a_ready;
   assign hs_b   = b_valid & b_ready;
   assign retire = (state_q == FULL) & out_ready;

   // Next-state: a FULL slot that retires behaves like EMPTY for refill.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (hs_a && hs_b)  state_d = FULL;
            else if (hs_a)     state_d = HAVE_A;
            else if (hs_b)     state_d = HAVE_B;
         end
         HAVE_A: if (hs_b) state_d = FULL;
         HAVE_B: if (hs_a) state_d = FULL;
         FULL: begin
            if (out_ready) begin
               if (hs_a && hs_b)  state_d = FULL;
               else if (hs_a)     state_d = HAVE_A;
               else if (hs_b)     state_d = HAVE_B;
               else               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign complete = (state_d == FULL) &&
                     ((state_q != FULL) || out_ready);
   assign b_fin    = hs_b ? b_data : b_q;
   assign sel_snap = cfg_load ? cfg_select : op_q;

`ifdef OPCOL_DIV_ZERO_GUARD_EN
   assign guard = complete && (sel_snap == SEL_DIV) &&
                  (b_fin == '0);
`else
   assign guard = 1'b0;
`endif

   // Datapath: capture on handshake, snapshot select/guard on completion.
   always_comb begin
      op_d  = cfg_load ? cfg_select : op_q;
      a_d   = hs_a ? a_data : a_q;
      b_d   = b_fin;
      sel_d = sel_q;
      dz_d  = retire ? 1'b0 : dz_q;
      if (complete) begin
         sel_d = sel_snap;
         dz_d  = guard;
         if (guard) b_d = ONE;
      end
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge CGRA_Clock) begin
      if (CGRA_Reset) begin
         state_q <= EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         sel_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         sel_q   <= sel_d;
         dz_q    <= dz_d;
      end
   end

   assign out_valid  = (state_q == FULL);
   assign out_a      = a_q;
   assign out_b      = b_q;
   assign out_select = sel_q;
   assign div_zero   = dz_q;

endmodule

// File: tb/tb_operand_collector.sv
// Directed self-checking bench for operand_collector.
// Expected div-zero results follow OPCOL_DIV_ZERO_GUARD_EN.
module tb_operand_collector;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_load;
   logic [3:0]    cfg_select;
   logic          a_valid, b_valid;
   logic [W-1:0]  a_data, b_data;
   logic          a_ready, b_ready;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_a, out_b;
   logic [3:0]    out_select;
   logic          div_zero;

   int passed = 0;
   int total  = 0;

   operand_collector #(.size(W)) dut (
      .CGRA_Clock (clk),
      .CGRA_Reset (rst),
      .cfg_load   (cfg_load),
      .cfg_select (cfg_select),
      .a_valid    (a_valid),
      .a_data     (a_data),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_data     (b_data),
      .b_ready    (b_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_select (out_select),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_load = 0; cfg_select = 0;
      a_valid = 0; b_valid = 0;
      a_data = 0; b_data = 0;
      out_ready = 0;
      step(); step();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", out_valid); else passed++;
      total++; if (out_a !== 0) $display("FAIL rst_a got %0h exp 0", out_a); else passed++;
      total++; if (out_b !== 0) $display("FAIL rst_b got %0h exp 0", out_b); else passed++;
      total++; if (out_select !== 0) $display("FAIL rst_sel got %0d exp 0", out_select); else passed++;
      total++; if (div_zero !== 1'b0) $display("FAIL rst_dz got %0b exp 0", div_zero); else passed++;
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL rst_ready got %0b%0b exp 00", a_ready, b_ready); else passed++;
      rst = 1'b0;
      #1;
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL empty_ready got %0b%0b exp 11", a_ready, b_ready); else passed++;
   endtask

   task automatic retire();
      out_ready = 1;
      step();
      out_ready = 0;
      total++; if (out_valid !== 1'b0) $display("FAIL retire_valid got %0b exp 0", out_valid); else passed++;
   endtask

   task automatic test_same_cycle();
      cfg_load = 1; cfg_select = 0;
      step();
      cfg_load = 0;
      a_valid = 1; a_data = 5;
      b_valid = 1; b_data = 7;
      step();
      a_valid = 0; b_valid = 0;
      total++; if (out_valid !== 1'b1) $display("FAIL same_valid got %0b exp 1", out_valid); else passed++;
      total++; if (out_a !== 5) $display("FAIL same_a got %0d exp 5", out_a); else passed++;
      total++; if (out_b !== 7) $display("FAIL same_b got %0d exp 7", out_b); else passed++;
      total++; if (out_select !== 0) $display("FAIL same_sel got %0d exp 0", out_select); else passed++;
      retire();
   endtask

   task automatic test_have_a();
      a_valid = 1; a_data = 32'h10;
      step();
      a_valid = 0;
      for (int i = 0; i < 3; i++) begin
         total++; if (out_valid !== 1'b0) $display("FAIL hava_valid got %0b exp 0", out_valid); else passed++;
         total++; if (a_ready !== 1'b0 || b_ready !== 1'b1) $display("FAIL hava_ready got %0b%0b exp 01", a_ready, b_ready); else passed++;
         if (i < 2) step();
      end
      b_valid = 1; b_data = 32'h20;
      step();
      b_valid = 0;
      total++; if (out_valid !== 1'b1) $display("FAIL hava_full got %0b exp 1", out_valid); else passed++;
      total++; if (out_a !== 32'h10 || out_b !== 32'h20) $display("FAIL hava_data got %0h/%0h exp 10/20", out_a, out_b); else passed++;
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL full_ready got %0b%0b exp 00", a_ready, b_ready); else passed++;
      retire();
   endtask

   task automatic test_back_to_back();
      a_valid = 1; a_data = 1;
      b_valid = 1; b_data = 2;
      step();
      a_data = 3; b_data = 4;
      for (int i = 0; i < 3; i++) begin
         total++; if (out_valid !== 1'b1) $display("FAIL stall_valid got %0b exp 1", out_valid); else passed++;
         total++; if (out_a !== 1 || out_b !== 2) $display("FAIL stall_data got %0d/%0d exp 1/2", out_a, out_b); else passed++;
         total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL stall_ready got %0b%0b exp 00", a_ready, b_ready); else passed++;
         step();
      end
      out_ready = 1;
      #1;
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL b2b_ready got %0b%0b exp 11", a_ready, b_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got %0b exp 1", out_valid); else passed++;
      total++; if (out_a !== 3 || out_b !== 4) $display("FAIL b2b_data1 got %0d/%0d exp 3/4", out_a, out_b); else passed++;
      a_data = 5; b_data = 6;
      step();
      total++; if (out_valid !== 1'b1 || out_a !== 5 || out_b !== 6) $display("FAIL b2b_data2 got %0b %0d/%0d exp 1 5/6", out_valid, out_a, out_b); else passed++;
      a_valid = 0; b_valid = 0;
      step();
      out_ready = 0;
      total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %0b exp 0", out_valid); else passed++;
   endtask

   task automatic test_div_zero();
      logic          exp_dz;
      logic [W-1:0]  exp_b;
`ifdef OPCOL_DIV_ZERO_GUARD_EN
      exp_dz = 1'b1; exp_b = 1;
`else
      exp_dz = 1'b0; exp_b = 0;
`endif
      cfg_load = 1; cfg_select = 3;
      step();
      cfg_load = 0;
      a_valid = 1; a_data = 100;
      b_valid = 1; b_data = 0;
      step();
      a_valid = 0; b_valid = 0;
      total++; if (out_select !== 3 || out_a !== 100) $display("FAIL dz_sel got %0d/%0d exp 3/100", out_select, out_a); else passed++;
      total++; if (div_zero !== exp_dz) $display("FAIL dz_flag got %0b exp %0b", div_zero, exp_dz); else passed++;
      total++; if (out_b !== exp_b) $display("FAIL dz_b got %0d exp %0d", out_b, exp_b); else passed++;
      retire();
      total++; if (div_zero !== 1'b0) $display("FAIL dz_clear got %0b exp 0", div_zero); else passed++;
      b_valid = 1; b_data = 0;
      step();
      b_valid = 0;
      a_valid = 1; a_data = 8;
      step();
      a_valid = 0;
      total++; if (div_zero !== exp_dz || out_b !== exp_b) $display("FAIL dz_held got %0b/%0d exp %0b/%0d", div_zero, out_b, exp_dz, exp_b); else passed++;
      retire();
      a_valid = 1; a_data = 9;
      b_valid = 1; b_data = 4;
      step();
      a_valid = 0; b_valid = 0;
      total++; if (div_zero !== 1'b0 || out_b !== 4) $display("FAIL dz_nonzero got %0b/%0d exp 0/4", div_zero, out_b); else passed++;
      retire();
   endtask

   task automatic test_reset_mid();
      b_valid = 1; b_data = 9;
      step();
      b_valid = 0;
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL havb_ready got %0b%0b exp 10", a_ready, b_ready); else passed++;
      rst = 1;
      step();
      rst = 0;
      a_valid = 1; a_data = 1;
      step();
      a_valid = 0;
      total++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %0b exp 0", out_valid); else passed++;
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b1) $display("FAIL mid_ready got %0b%0b exp 01", a_ready, b_ready); else passed++;
      b_valid = 1; b_data = 11;
      step();
      b_valid = 0;
      total++; if (out_valid !== 1'b1 || out_a !== 1 || out_b !== 11) $display("FAIL mid_pair got %0b %0d/%0d exp 1 1/11", out_valid, out_a, out_b); else passed++;
      total++; if (out_select !== 0) $display("FAIL mid_sel got %0d exp 0", out_select); else passed++;
      retire();
   endtask

   task automatic test_cfg_snapshot();
      a_valid = 1; a_data = 1;
      step();
      a_valid = 0;
      b_valid = 1; b_data = 2;
      cfg_load = 1; cfg_select = 6;
      step();
      b_valid = 0;
      total++; if (out_valid !== 1'b1 || out_select !== 6) $display("FAIL snap_sel got %0b/%0d exp 1/6", out_valid, out_select); else passed++;
      cfg_select = 2;
      step();
      cfg_load = 0;
      total++; if (out_select !== 6) $display("FAIL snap_hold1 got %0d exp 6", out_select); else passed++;
      step();
      total++; if (out_select !== 6) $display("FAIL snap_hold2 got %0d exp 6", out_select); else passed++;
      retire();
      a_valid = 1; b_valid = 1;
      a_data = 7; b_data = 8;
      step();
      a_valid = 0; b_valid = 0;
      total++; if (out_select !== 2) $display("FAIL snap_new got %0d exp 2", out_select); else passed++;
      retire();
   endtask

   initial begin
      test_reset();
      test_same_cycle();
      test_have_a();
      test_back_to_back();
      test_div_zero();
      test_reset_mid();
      test_cfg_snapshot();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
